// File: rtl/sipo_ctrl.sv
// Frames a serial bit stream into WIDTH-bit words behind a held, valid/ready-handshaked output register.
// A word shows on par_out one cycle after its last bit; a word that completes while the previous one is still unconsumed is dropped and latched in overrun.
module sipo_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             ovr_clr,
    input  logic             ready,
    output logic [WIDTH-1:0] par_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] par_q, par_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] bit_mask;
    logic             word_done;
    logic             ovr_set;

    // Counter is 0 in IDLE, so the first bit maps to the same slot as bit index 0.
    always_comb begin
        pos      = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);
        bit_mask = WIDTH'(1) << pos;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = sin ? bit_mask : '0;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = sin ? (shreg_q | bit_mask) : (shreg_q & ~bit_mask);
                if (cnt_q == LAST_IDX) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The completing word is taken from shreg_d so the last bit lands in the same edge.
    always_comb begin
        par_d   = par_q;
        vld_d   = vld_q;
        ovr_set = 1'b0;
        if (word_done) begin
            if (!vld_q || ready) begin
                par_d = shreg_d;
                vld_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (vld_q && ready) begin
            vld_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
        end
    end

    assign par_out = par_q;
    assign valid   = vld_q;
    assign busy    = (state_q == ST_SHIFT);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_sipo_ctrl.sv
// Bench for sipo_ctrl: two instances (LSB-first and MSB-first) share stimulus; a scoreboard queue per instance
// holds the words the reference model says were loaded, and a negedge monitor pops them on each handshake.
module tb_sipo_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sin = 1'b0;
    logic         ovr_clr = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] par_l, par_m;
    logic         valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m;

    sipo_ctrl #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .ovr_clr(ovr_clr), .ready(ready),
        .par_out(par_l), .valid(valid_l), .busy(busy_l), .overrun(ovr_l)
    );

    sipo_ctrl #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .ovr_clr(ovr_clr), .ready(ready),
        .par_out(par_m), .valid(valid_m), .busy(busy_m), .overrun(ovr_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endtask

    // Reference model: a word is a list of received bits; the value is built arithmetically per bit order.
    int q_l[$];
    int q_m[$];
    bit m_in_word = 0;
    int m_nbits = 0;
    int acc_l = 0;
    int acc_m = 0;
    bit m_valid = 0;
    bit m_ovr = 0;

    task automatic model_reset();
        m_in_word = 0;
        m_nbits   = 0;
        acc_l     = 0;
        acc_m     = 0;
        m_valid   = 0;
        m_ovr     = 0;
        q_l.delete();
        q_m.delete();
    endtask

    task automatic model_step();
        bit complete;
        bit lost;
        complete = 0;
        lost     = 0;
        if (!rst) begin
            model_reset();
            return;
        end
        if (!m_in_word) begin
            if (start) begin
                m_in_word = 1;
                acc_l     = int'(sin);
                acc_m     = int'(sin) << (W - 1);
                m_nbits   = 1;
            end
        end else begin
            acc_l   = acc_l + (int'(sin) << m_nbits);
            acc_m   = acc_m + (int'(sin) << (W - 1 - m_nbits));
            m_nbits = m_nbits + 1;
            if (m_nbits == W) begin
                complete  = 1;
                m_in_word = 0;
                m_nbits   = 0;
            end
        end
        if (complete) begin
            if (!m_valid || ready) begin
                m_valid = 1;
                q_l.push_back(acc_l);
                q_m.push_back(acc_m);
            end else begin
                lost = 1;
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
        if (lost) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
    endtask

    // One clock: let the model see the inputs sampled at this edge, then drive the next cycle's inputs.
    task automatic cycle(input logic st, input logic s, input logic rd, input logic oc);
        @(posedge clk);
        model_step();
        #1;
        start   = st;
        sin     = s;
        ready   = rd;
        ovr_clr = oc;
    endtask

    task automatic send(input logic [W-1:0] seq, input logic rd);
        for (int i = 0; i < W; i++) cycle(i == 0, seq[i], rd, 1'b0);
    endtask

    bit mon_en = 0;
    logic [W-1:0] prev_par_l;
    logic prev_hold = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid_lsb", valid_l, m_valid);
            chk("valid_msb", valid_m, m_valid);
            chk("busy_lsb", busy_l, m_in_word);
            chk("busy_msb", busy_m, m_in_word);
            chk("overrun_lsb", ovr_l, m_ovr);
            chk("overrun_msb", ovr_m, m_ovr);
            if (prev_hold && valid_l) chk("par_stable", par_l, prev_par_l);
            if (valid_l && ready) begin
                if (q_l.size() == 0) chk("pop_lsb_nonempty", 0, 1);
                else chk("word_lsb", par_l, q_l.pop_front());
            end
            if (valid_m && ready) begin
                if (q_m.size() == 0) chk("pop_msb_nonempty", 0, 1);
                else chk("word_msb", par_m, q_m.pop_front());
            end
            prev_par_l = par_l;
            prev_hold  = valid_l && !ready && rst;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1;
        rst = 1'b1;

        // Idle after reset: nothing moves.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            chk("idle_par_lsb", par_l, 0);
        end

        // Single word 1,0,1,1.
        send(4'b1101, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("single_par_lsb", par_l, 4'b1101);
        chk("single_par_msb", par_m, 4'b1011);
        chk("single_valid", valid_l, 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back words, no gap.
        send(4'b1101, 1'b1);
        send(4'b0110, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_second_lsb", par_l, 4'b0110);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun under back-pressure, then clear and drain.
        send(4'b1101, 1'b0);
        send(4'b0011, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_set", ovr_l, 1);
        chk("ovr_held_par", par_l, 4'b1101);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ovr_cleared", ovr_l, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drained_valid", valid_l, 0);

        // Accept and complete on the same edge.
        send(4'b1101, 1'b0);
        for (int i = 0; i < W; i++) cycle(i == 0, (4'b1010 >> i) & 1'b1, i == W - 1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("simul_par_lsb", par_l, 4'b1010);
        chk("simul_valid", valid_l, 1);
        chk("simul_ovr", ovr_l, 0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset two bits into a word.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        model_step();
        #1;
        start = 1'b0;
        sin   = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send(4'b1001, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_reset_word", par_l, 4'b1001);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);

        // A start mid-word is data, not a restart.
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ignored_start_word", par_l, 4'b0110);
        chk("ignored_start_valid", valid_l, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_lsb_empty", q_l.size(), 0);
        chk("queue_msb_empty", q_m.size(), 0);
        mon_en = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
